// File: rtl/mips_pkg.sv
// Shared types and defaults for the data-memory access controller.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int TIMEOUT_DEF = 16;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Word-addressed memory bus between the controller (master) and memory (slave).
interface dmem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/be_gen.sv
// Byte-lane enables and store-data replication for a single access.
module be_gen
    import mips_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic        i_byte_sel,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_data;
        if (i_byte_sel) begin
            o_be    = lane_onehot(i_addr);
            o_wdata = {4{i_data[7:0]}};
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: issues one bus access per request,
// stalls the pipeline until it completes, and bounds the wait with a timeout.
//
// state | meaning
// IDLE  | no access outstanding; accept an aligned request
// BUSY  | bus_req held, waiting for bus_ack or timeout
// DONE  | access finished, pipeline released for one cycle
module dmem_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic        storeselectM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        misalignM,
    output logic        buserrM,
    dmem_ctrl_if.master bus
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_we;
    logic [31:0]   r_rdata;
    logic          r_misalign;
    logic          r_buserr;

    logic        w_req;
    logic        w_aligned;
    logic        w_issue;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Only word accesses carry an alignment constraint; byte accesses never trap.
    assign w_req     = memreadM | memwriteM;
    assign w_aligned = storeselectM | (aluoutM[1:0] == 2'b00);
    assign w_issue   = w_req & w_aligned;
    assign w_timeout = (r_cnt == CNT_LAST);

    be_gen u_be_gen (
        .i_addr     (aluoutM[1:0]),
        .i_byte_sel (storeselectM & memwriteM),
        .i_data     (writedataM),
        .o_be       (w_be),
        .o_wdata    (w_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.bus_ack || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_issue) begin
                        r_addr  <= {aluoutM[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_we    <= memwriteM;
                    end else if (w_req) begin
                        r_misalign <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        if (!r_we) begin
                            r_rdata <= bus.bus_rdata;
                        end
                    end else if (w_timeout) begin
                        r_buserr <= 1'b1;
                        r_rdata  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // bus_req is decoded from state so an async reset drops it immediately.
    assign bus.bus_req   = (r_state == BUSY);
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.bus_be    = r_be;

    assign stallM    = w_issue & (r_state != DONE);
    assign readdataM = r_rdata;
    assign misalignM = r_misalign;
    assign buserrM   = r_buserr;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus randomized checks of dmem_ctrl against a transaction-level model.
module tb_dmem_ctrl;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        memreadM;
    logic        memwriteM;
    logic        storeselectM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        misalignM;
    logic        buserrM;

    dmem_ctrl_if bus_if ();

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .memreadM     (memreadM),
        .memwriteM    (memwriteM),
        .storeselectM (storeselectM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .misalignM    (misalignM),
        .buserrM      (buserrM),
        .bus          (bus_if)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_buserr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memreadM     = 1'b0;
        memwriteM    = 1'b0;
        storeselectM = 1'b0;
        aluoutM      = '0;
        writedataM   = '0;
    endtask

    // One aligned access; ack_at = BUSY cycle in which ack is given (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic bsel,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdat);
        int          busy_n;
        int          stall_n;
        int          exp_busy;
        bit          done;
        bit          acked;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        ebe      = (bsel && wr) ? 4'(1 << addr[1:0]) : 4'hF;
        ewd      = (bsel && wr) ? {24'h0, wd[7:0]} * 32'h0101_0101 : wd;
        acked    = (ack_at >= 1 && ack_at <= TO);
        exp_busy = acked ? ack_at : TO;
        busy_n   = 0;
        stall_n  = 0;
        done     = 0;
        @(negedge clk);
        memreadM     = rd;
        memwriteM    = wr;
        storeselectM = bsel;
        aluoutM      = addr;
        writedataM   = wd;
        for (int c = 0; c < TO + 10 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (stallM) stall_n++;
            if (bus_if.bus_req) begin
                busy_n++;
                check("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
                check("bus_be", {28'h0, bus_if.bus_be}, {28'h0, ebe});
                check("bus_we", {31'h0, bus_if.bus_we}, {31'h0, wr});
                check("bus_wdata", bus_if.bus_wdata, ewd);
                bus_if.bus_ack   = (busy_n == ack_at);
                bus_if.bus_rdata = (busy_n == ack_at) ? rdat : $urandom;
            end else begin
                bus_if.bus_ack = 1'b0;
                if (busy_n > 0) done = 1;
            end
        end
        if (!acked) begin
            exp_buserr = 1'b1;
            exp_rdata  = '0;
        end else if (!wr) begin
            exp_rdata = rdat;
        end
        check("access_completed", {31'h0, done}, 32'h1);
        check("bus_req_cycles", busy_n, exp_busy);
        check("stall_cycles", stall_n, exp_busy + 1);
        check("readdataM", readdataM, exp_rdata);
        check("buserrM", {31'h0, buserrM}, {31'h0, exp_buserr});
        check("misalignM", {31'h0, misalignM}, {31'h0, exp_mis});
        idle_inputs();
        bus_if.bus_ack = 1'b0;
    endtask

    task automatic do_misalign(input logic rd, input logic wr, input logic [31:0] addr);
        @(negedge clk);
        memreadM     = rd;
        memwriteM    = wr;
        storeselectM = 1'b0;
        aluoutM      = addr;
        writedataM   = $urandom;
        #1;
        check("mis_stallM", {31'h0, stallM}, 32'h0);
        check("mis_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        @(negedge clk);
        #1;
        exp_mis = 1'b1;
        check("mis_bus_req_next", {31'h0, bus_if.bus_req}, 32'h0);
        check("mis_misalignM", {31'h0, misalignM}, 32'h1);
        idle_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, {31'h0, bus_if.bus_req}, 32'h0);
        check({tag, "_bus_we"}, {31'h0, bus_if.bus_we}, 32'h0);
        check({tag, "_bus_be"}, {28'h0, bus_if.bus_be}, 32'h0);
        check({tag, "_bus_addr"}, bus_if.bus_addr, 32'h0);
        check({tag, "_bus_wdata"}, bus_if.bus_wdata, 32'h0);
        check({tag, "_readdataM"}, readdataM, 32'h0);
        check({tag, "_misalignM"}, {31'h0, misalignM}, 32'h0);
        check({tag, "_buserrM"}, {31'h0, buserrM}, 32'h0);
        check({tag, "_stallM"}, {31'h0, stallM}, 32'h0);
    endtask

    initial begin
        int          busy_n;
        logic        rd;
        logic        wr;
        logic        bsel;
        logic [31:0] addr;
        logic [1:0]  kind;
        int          ack_at;

        reset = 1'b0;
        idle_inputs();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        exp_rdata  = '0;
        exp_mis    = 1'b0;
        exp_buserr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_5678, 1, 32'h0);
        do_access(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 3, 32'h5555_AAAA);
        do_misalign(1'b0, 1'b1, 32'h0000_0102);
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h0BAD_F00D);
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h8765_4321, 2, 32'h0);
        check("misalign_sticky", {31'h0, misalignM}, 32'h1);

        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0);
        @(negedge clk);
        #1;
        check("timeout_idle_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        check("timeout_idle_stallM", {31'h0, stallM}, 32'h0);

        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hA5A5_A5A5;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("ack_idle_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
            check("ack_idle_readdataM", readdataM, exp_rdata);
        end
        bus_if.bus_ack = 1'b0;

        for (int n = 0; n < 40; n++) begin
            kind   = 2'($urandom_range(1, 3));
            rd     = kind[0];
            wr     = kind[1];
            bsel   = 1'($urandom_range(0, 1));
            addr   = $urandom;
            if (!bsel && $urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            if (!bsel && addr[1:0] != 2'b00) begin
                do_misalign(rd, wr, addr);
            end else begin
                do_access(rd, wr, bsel, addr, $urandom, ack_at, $urandom);
            end
        end

        @(negedge clk);
        memreadM = 1'b1;
        aluoutM  = 32'h0000_0400;
        busy_n   = 0;
        for (int c = 0; c < 10 && busy_n < 2; c++) begin
            @(negedge clk);
            #1;
            if (bus_if.bus_req) busy_n++;
        end
        check("rst_reached_busy2", busy_n, 2);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_async_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
        @(negedge clk);
        reset      = 1'b1;
        exp_rdata  = '0;
        exp_mis    = 1'b0;
        exp_buserr = 1'b0;
        #1;
        check_all_zero("post_reset");
        repeat (2) @(negedge clk);
        #1;
        check("no_retry_bus_req", {31'h0, bus_if.bus_req}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
